// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store memory port: size encodings,
// FSM state encoding and the byte-select generator also used by the
// aligner testbench.
package lsu_mem_port_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Byte select for an access of the given size at byte offset a.
  // The illegal size yields no lanes.
  function automatic logic [3:0] gen_sel(input logic [1:0] size,
                                         input logic [1:0] a);
    logic [3:0] sel;
    case (size)
      SZ_B:    sel = 4'b0001 << a;
      SZ_H:    sel = 4'b0011 << a;
      SZ_W:    sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/lsu_lane_gen.sv
// Combinational lane generator: maps access size, byte offset and
// right-justified store data to byte select, lane-replicated store data
// and a misalignment flag.
module lsu_lane_gen
  import lsu_mem_port_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_sh,
  output logic        misaligned
);

  // Replicate narrow store data across lanes and flag illegal offsets.
  always_comb begin
    sel        = gen_sel(size, addr_lo);
    wdata_sh   = wdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wdata_sh   = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      SZ_H: begin
        wdata_sh   = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_W: begin
        wdata_sh   = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        // Size 11 is never a legal access.
        wdata_sh   = wdata;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store bus port between EX and data memory. Accepts one op in IDLE,
// drives a registered req/gnt request, waits for rvalid on loads and hands
// the raw word plus byte select and offset to the load aligner.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_wr,
  input  logic [1:0]        op_size,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              ld_valid,
  output logic [3:0]        ld_sel,
  output logic [1:0]        ld_addr,
  output logic [31:0]       ld_data
);

  state_t            state_r;
  state_t            next_state_s;

  logic [3:0]        lane_sel_s;
  logic [31:0]       lane_wdata_s;
  logic              lane_mis_s;

  logic              stall_s;
  logic              accept_s;
  logic              mis_set_s;
  logic              gnt_done_s;
  logic              resp_done_s;

  logic              misalign_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [3:0]        mem_be_r;
  logic [31:0]       mem_wdata_r;
  logic [1:0]        addr_lo_r;
  logic              ld_valid_r;
  logic [3:0]        ld_sel_r;
  logic [1:0]        ld_addr_r;
  logic [31:0]       ld_data_r;

  lsu_lane_gen u_lane_gen (
    .size       (op_size),
    .addr_lo    (op_addr[1:0]),
    .wdata      (op_wdata),
    .sel        (lane_sel_s),
    .wdata_sh   (lane_wdata_s),
    .misaligned (lane_mis_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic, combinational stall and per-cycle control strobes.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    accept_s     = 1'b0;
    mis_set_s    = 1'b0;
    gnt_done_s   = 1'b0;
    resp_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (op_valid) begin
          if (lane_mis_s) begin
            // Rejected op: no bus cycle and no stall.
            mis_set_s    = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            accept_s     = 1'b1;
            stall_s      = 1'b1;
            next_state_s = ST_REQ;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        // A same-cycle rvalid is ignored here; the response comes later.
        if (mem_gnt) begin
          gnt_done_s   = 1'b1;
          next_state_s = mem_we_r ? ST_IDLE : ST_RESP;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_RESP: begin
        stall_s = 1'b1;
        if (mem_rvalid) begin
          resp_done_s  = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        stall_s      = 1'b0;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Bus request/data capture, misalign pulse and load result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      addr_lo_r   <= 2'b00;
      ld_valid_r  <= 1'b0;
      ld_sel_r    <= 4'b0000;
      ld_addr_r   <= 2'b00;
      ld_data_r   <= 32'h0000_0000;
    end else begin
      misalign_r <= mis_set_s;
      ld_valid_r <= resp_done_s;
      if (accept_s) begin
        // Bus fields stay frozen from accept until the next accept.
        mem_req_r   <= 1'b1;
        mem_we_r    <= op_wr;
        mem_addr_r  <= {op_addr[ADDR_W-1:2], 2'b00};
        mem_be_r    <= lane_sel_s;
        mem_wdata_r <= lane_wdata_s;
        addr_lo_r   <= op_addr[1:0];
      end else if (gnt_done_s) begin
        mem_req_r <= 1'b0;
      end
      if (resp_done_s) begin
        ld_sel_r  <= mem_be_r;
        ld_addr_r <= addr_lo_r;
        ld_data_r <= mem_rdata;
      end
    end
  end

  assign stall     = stall_s;
  assign misalign  = misalign_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;
  assign ld_valid  = ld_valid_r;
  assign ld_sel    = ld_sel_r;
  assign ld_addr   = ld_addr_r;
  assign ld_data   = ld_data_r;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a table of single store/misaligned ops
// plus hand-written load, back-to-back and reset-in-RESP sequences.
module tb_lsu_mem_port;
  import lsu_mem_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_wr;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        stall;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [3:0]  ld_sel;
  logic [1:0]  ld_addr;
  logic [31:0] ld_data;

  int n_vec = 0;
  int n_err = 0;

  lsu_mem_port #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_wr      (op_wr),
    .op_size    (op_size),
    .op_addr    (op_addr),
    .op_wdata   (op_wdata),
    .stall      (stall),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ld_valid   (ld_valid),
    .ld_sel     (ld_sel),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] wsh;
    logic        mis;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    op_valid = v;
    op_wr    = wr;
    op_size  = sz;
    op_addr  = a;
    op_wdata = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chkb({tag, "_stall"},    stall,    1'b0);
    chkb({tag, "_misalign"}, misalign, 1'b0);
    chkb({tag, "_mem_req"},  mem_req,  1'b0);
    chkb({tag, "_mem_we"},   mem_we,   1'b0);
    chk ({tag, "_mem_addr"}, mem_addr, 32'h0000_0000);
    chk ({tag, "_mem_be"},   {28'd0, mem_be}, 32'h0000_0000);
    chk ({tag, "_mem_wdata"}, mem_wdata, 32'h0000_0000);
    chkb({tag, "_ld_valid"}, ld_valid, 1'b0);
    chk ({tag, "_ld_sel"},   {28'd0, ld_sel}, 32'h0000_0000);
    chk ({tag, "_ld_addr"},  {30'd0, ld_addr}, 32'h0000_0000);
    chk ({tag, "_ld_data"},  ld_data,  32'h0000_0000);
  endtask

  initial begin
    vecs[0]  = '{1'b1, SZ_W,  32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, SZ_B,  32'h0000_2003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 1'b0};
    vecs[2]  = '{1'b1, SZ_B,  32'h0000_2000, 32'h1234_5678, 4'b0001, 32'h7878_7878, 1'b0};
    vecs[3]  = '{1'b1, SZ_B,  32'h0000_2001, 32'h0000_003C, 4'b0010, 32'h3C3C_3C3C, 1'b0};
    vecs[4]  = '{1'b1, SZ_B,  32'h0000_2002, 32'hAABB_CC11, 4'b0100, 32'h1111_1111, 1'b0};
    vecs[5]  = '{1'b1, SZ_H,  32'h0000_2000, 32'hCAFE_BABE, 4'b0011, 32'hBABE_BABE, 1'b0};
    vecs[6]  = '{1'b1, SZ_H,  32'h0000_2002, 32'h0000_1234, 4'b1100, 32'h1234_1234, 1'b0};
    vecs[7]  = '{1'b0, SZ_W,  32'h0000_4001, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, SZ_H,  32'h0000_4003, 32'h0000_5555, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, SZ_H,  32'h0000_2001, 32'h0000_7777, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, SZ_W,  32'h0000_2002, 32'h0000_8888, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 2'b11, 32'h0000_2000, 32'h0000_9999, 4'b0000, 32'h0000_0000, 1'b1};

    rst        = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0000_0000;
    set_op(1'b0, 1'b0, SZ_B, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    next_cycle();

    // Table: one op per entry; aligned stores get an immediate grant.
    for (int i = 0; i < NV; i++) begin
      set_op(1'b1, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chkb($sformatf("v%0d_stall_c0", i), stall, !vecs[i].mis);
      next_cycle();
      if (!vecs[i].mis) begin
        mem_gnt = 1'b1;
        @(negedge clk);
        chkb($sformatf("v%0d_mem_req", i), mem_req, 1'b1);
        chkb($sformatf("v%0d_mem_we", i), mem_we, vecs[i].wr);
        chk ($sformatf("v%0d_mem_addr", i), mem_addr, {vecs[i].addr[31:2], 2'b00});
        chk ($sformatf("v%0d_mem_be", i), {28'd0, mem_be}, {28'd0, vecs[i].sel});
        chk ($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wsh);
        chkb($sformatf("v%0d_stall_c1", i), stall, 1'b1);
        next_cycle();
        op_valid = 1'b0;
        mem_gnt  = 1'b0;
        @(negedge clk);
        chkb($sformatf("v%0d_req_drop", i), mem_req, 1'b0);
        chkb($sformatf("v%0d_stall_c2", i), stall, 1'b0);
        chkb($sformatf("v%0d_no_ld", i), ld_valid, 1'b0);
        next_cycle();
      end else begin
        op_valid = 1'b0;
        @(negedge clk);
        chkb($sformatf("v%0d_misalign", i), misalign, 1'b1);
        chkb($sformatf("v%0d_no_req", i), mem_req, 1'b0);
        chkb($sformatf("v%0d_stall_c1", i), stall, 1'b0);
        next_cycle();
        @(negedge clk);
        chkb($sformatf("v%0d_mis_pulse_end", i), misalign, 1'b0);
        next_cycle();
      end
    end

    // LH 0x3002: grant delayed 3 cycles; rvalid alongside gnt is ignored.
    set_op(1'b1, 1'b0, SZ_H, 32'h0000_3002, 32'h0);
    @(negedge clk);
    chkb("lh_stall_acc", stall, 1'b1);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chkb($sformatf("lh_wait%0d_req", k), mem_req, 1'b1);
      chk ($sformatf("lh_wait%0d_be", k), {28'd0, mem_be}, 32'h0000_000C);
      chk ($sformatf("lh_wait%0d_addr", k), mem_addr, 32'h0000_3000);
      chkb($sformatf("lh_wait%0d_we", k), mem_we, 1'b0);
      chkb($sformatf("lh_wait%0d_stall", k), stall, 1'b1);
      next_cycle();
    end
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    chkb("lh_gnt_req", mem_req, 1'b1);
    next_cycle();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    chkb("lh_resp_req", mem_req, 1'b0);
    chkb("lh_resp_stall", stall, 1'b1);
    chkb("lh_resp_no_ld", ld_valid, 1'b0);
    next_cycle();
    mem_rvalid = 1'b0;
    op_valid   = 1'b0;
    @(negedge clk);
    chkb("lh_ld_valid", ld_valid, 1'b1);
    chk ("lh_ld_sel", {28'd0, ld_sel}, 32'h0000_000C);
    chk ("lh_ld_addr", {30'd0, ld_addr}, 32'h0000_0002);
    chk ("lh_ld_data", ld_data, 32'h1234_5678);
    chkb("lh_stall_done", stall, 1'b0);
    next_cycle();
    @(negedge clk);
    chkb("lh_ld_pulse_end", ld_valid, 1'b0);
    chk ("lh_ld_data_hold", ld_data, 32'h1234_5678);
    next_cycle();

    // LB 0x5001 then SW 0x5008 back-to-back, then a stray rvalid in IDLE.
    set_op(1'b1, 1'b0, SZ_B, 32'h0000_5001, 32'h0);
    @(negedge clk);
    chkb("b2b_lb_stall", stall, 1'b1);
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    chk ("b2b_lb_be", {28'd0, mem_be}, 32'h0000_0002);
    next_cycle();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_AB00;
    @(negedge clk);
    chkb("b2b_lb_resp_stall", stall, 1'b1);
    next_cycle();
    mem_rvalid = 1'b0;
    set_op(1'b1, 1'b1, SZ_W, 32'h0000_5008, 32'h1122_3344);
    @(negedge clk);
    chkb("b2b_ld_valid", ld_valid, 1'b1);
    chk ("b2b_ld_sel", {28'd0, ld_sel}, 32'h0000_0002);
    chk ("b2b_ld_addr", {30'd0, ld_addr}, 32'h0000_0001);
    chk ("b2b_ld_data", ld_data, 32'h0000_AB00);
    chkb("b2b_sw_accept", stall, 1'b1);
    next_cycle();
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_EEEE;
    @(negedge clk);
    chkb("b2b_sw_req", mem_req, 1'b1);
    chkb("b2b_sw_we", mem_we, 1'b1);
    chk ("b2b_sw_addr", mem_addr, 32'h0000_5008);
    chk ("b2b_sw_be", {28'd0, mem_be}, 32'h0000_000F);
    chk ("b2b_sw_wdata", mem_wdata, 32'h1122_3344);
    chkb("b2b_sw_no_ld", ld_valid, 1'b0);
    next_cycle();
    mem_gnt  = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    chkb("b2b_sw_req_drop", mem_req, 1'b0);
    chkb("b2b_sw_stall_drop", stall, 1'b0);
    chkb("stray_rv_no_ld0", ld_valid, 1'b0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chkb("stray_rv_no_ld1", ld_valid, 1'b0);
    chk ("stray_rv_data_hold", ld_data, 32'h0000_AB00);
    next_cycle();

    // LW 0x6000, reset while waiting in RESP, then a late rvalid.
    set_op(1'b1, 1'b0, SZ_W, 32'h0000_6000, 32'h0);
    @(negedge clk);
    chkb("rst_lw_stall", stall, 1'b1);
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    chkb("rst_lw_req", mem_req, 1'b1);
    next_cycle();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    chkb("rst_lw_resp_stall", stall, 1'b1);
    next_cycle();
    rst        = 1'b0;
    op_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA_55AA;
    @(negedge clk);
    chk_reset_vals("rst_resp");
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chkb("rst_late_rv_no_ld", ld_valid, 1'b0);
    chk ("rst_late_rv_data", ld_data, 32'h0000_0000);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
